fb_scanout: RTL

//  Display-side consumer of the 320x240x24 frame buffer filled by the map/sprite draw stages.

---
 rtl/fb_scanout.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fb_scanout.sv
// fb_scanout: VGA 640x480@60 scan-out of a 320x240x24 frame buffer, 2x upscaled.
// A clock-enable divider makes the pixel tick; a two-stage pipeline (address
// issue, then data/sync capture) keeps rgb, hsync, vsync and blank aligned.
module fb_scanout #(
    parameter int CLK_DIV    = 4,
    parameter int RD_LATENCY = 1,
    parameter int H_VIS      = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VIS      = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33
) (
    input  logic        clk,
    input  logic        rst,
    output logic [16:0] fb_rd_addr,
    output logic        fb_rd_en,
    input  logic [23:0] fb_rd_data,
    output logic        pix_tick,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic [23:0] rgb,
    output logic        vblank_start
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_VIS_W  = HW'(H_VIS);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_VIS_W  = VW'(V_VIS);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_VIS + V_FP + V_SYNC - 1);

    // Read data must settle inside one pixel period; if the build is
    // misconfigured, show black rather than sampling unsettled data.
    localparam bit LAT_OK = (RD_LATENCY < CLK_DIV);

    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;

    // stage-0 combinational values from the counters
    logic          vis_s0, hs_s0, vs_s0;
    logic [16:0]   vhalf, hhalf, addr_s0;

    // stage-0 registers (address issue + delayed timing flags)
    logic [16:0]   addr_q;
    logic          en_q, hs_q, vs_q;

    // stage-1 registers (visible outputs)
    logic          hsync_q, vsync_q, blank_q;
    logic [23:0]   rgb_q;

    assign pix_tick     = (div_q == DIV_LAST);
    assign vblank_start = pix_tick && (h_q == '0) && (v_q == V_VIS_W);

    // Next-state for the clock divider and the h/v raster counters
    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        h_d   = h_q;
        v_d   = v_q;
        if (pix_tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Stage 0: visibility, frame-buffer address (v/2*320 + h/2 via shifts), sync windows
    always_comb begin
        vis_s0  = (h_q < H_VIS_W) && (v_q < V_VIS_W);
        vhalf   = 17'(v_q >> 1);
        hhalf   = 17'(h_q >> 1);
        addr_s0 = vis_s0 ? ((vhalf << 8) + (vhalf << 6) + hhalf) : '0;
        hs_s0   = (h_q >= HS_BEG) && (h_q <= HS_END);
        vs_s0   = (v_q >= VS_BEG) && (v_q <= VS_END);
    end

    // Divider and raster counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    // Pipeline: stage 0 issues the read, stage 1 captures data one pixel later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            en_q    <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            blank_q <= 1'b1;
            rgb_q   <= '0;
        end else if (pix_tick) begin
            addr_q  <= addr_s0;
            en_q    <= vis_s0;
            hs_q    <= hs_s0;
            vs_q    <= vs_s0;
            rgb_q   <= (en_q && LAT_OK) ? fb_rd_data : '0;
            blank_q <= ~en_q;
            hsync_q <= ~hs_q;
            vsync_q <= ~vs_q;
        end
    end

    assign fb_rd_addr = addr_q;
    assign fb_rd_en   = en_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign blank      = blank_q;
    assign rgb        = rgb_q;

endmodule
